gcd_scheduler: RTL and testbench

Shares a single subtraction-based GCD core among `NUM_REQ` requesters. It arbitrates round-robin between requesters and loads the granted operand pair into the core. It waits for the core's done indication, then returns the result tagged with the requester ID over a valid/ready response channel. Zero operands never reach the core, because the core does not terminate on them.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_scheduler_rr_arbiter.sv | 35 +++
 rtl/gcd_scheduler.sv | 122 ++++++++++++
 tb/tb_gcd_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD request scheduler.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } sched_state_t;

   localparam int GCD_WIDTH = 8;

endpackage

// File: rtl/gcd_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   int unsigned       k;
   logic [ID_W-1:0]   k_w;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      k     = 0;
      k_w   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // Scan from the pointer, wrapping past the last requester.
         k = 32'(ptr_i) + 32'(i);
         if (k >= 32'(NUM_REQ)) k = k - 32'(NUM_REQ);
         k_w = ID_W'(k);
         if (!any_o && req_i[k_w]) begin
            any_o      = 1'b1;
            gnt_o[k_w] = 1'b1;
            idx_o      = k_w;
         end
      end
   end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one subtraction GCD core among NUM_REQ requesters,
// returning ID-tagged results over a valid/ready channel.
module gcd_scheduler
   import gcd_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = GCD_WIDTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_x,
   input  logic [NUM_REQ*WIDTH-1:0]   req_y,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       core_load,
   output logic [WIDTH-1:0]           core_x,
   output logic [WIDTH-1:0]           core_y,
   input  logic                       core_done,
   input  logic [WIDTH-1:0]           core_result,
   output logic                       rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]           rsp_gcd,
   input  logic                       rsp_ready
);

   localparam int ID_W = $clog2(NUM_REQ);

   sched_state_t     state_q;
   logic [ID_W-1:0]  ptr_q;
   logic [ID_W-1:0]  ptr_d;
   logic [ID_W-1:0]  id_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] gcd_q;
   logic             load_q;
   logic             rsp_valid_q;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic               idle;
   logic [WIDTH-1:0]   x_d;
   logic [WIDTH-1:0]   y_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign idle = (state_q == IDLE) && !reset;
   assign x_d  = req_x[gnt_idx*WIDTH +: WIDTH];
   assign y_d  = req_y[gnt_idx*WIDTH +: WIDTH];

   always_comb begin
      ptr_d = id_q + 1'b1;
      if (32'(id_q) == NUM_REQ - 1) ptr_d = '0;
   end

   assign req_ready = idle ? gnt : '0;
   assign core_load = load_q;
   assign core_x    = x_q;
   assign core_y    = y_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = id_q;
   assign rsp_gcd   = gcd_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         x_q         <= '0;
         y_q         <= '0;
         gcd_q       <= '0;
         load_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         load_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (gnt_any) begin
                  id_q <= gnt_idx;
                  x_q  <= x_d;
                  y_q  <= y_d;
                  // A zero operand would never terminate the core.
                  if (x_d == '0 || y_d == '0) begin
                     gcd_q       <= x_d | y_d;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end else begin
                     load_q  <= 1'b1;
                     state_q <= LOAD;
                  end
               end
            end
            LOAD: state_q <= RUN;
            RUN: begin
               if (core_done) begin
                  gcd_q       <= core_result;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  ptr_q       <= ptr_d;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Scoreboard bench for gcd_scheduler with a behavioural subtraction core.
module tb_gcd_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_x;
   logic [N*W-1:0] req_y;
   logic [N-1:0]   req_ready;
   logic           core_load;
   logic [W-1:0]   core_x;
   logic [W-1:0]   core_y;
   logic           core_done;
   logic [W-1:0]   core_result;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_gcd;
   logic           rsp_ready;

   always #5 clock = ~clock;

   gcd_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_ready   (req_ready),
      .core_load   (core_load),
      .core_x      (core_x),
      .core_y      (core_y),
      .core_done   (core_done),
      .core_result (core_result),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_gcd     (rsp_gcd),
      .rsp_ready   (rsp_ready)
   );

   // Behavioural subtraction GCD core sharing the reset.
   logic [W-1:0] cx, cy;
   logic         busy;

   always @(posedge clock) begin
      if (reset) busy <= 1'b0;
      else if (core_load) begin
         cx   <= core_x;
         cy   <= core_y;
         busy <= 1'b1;
      end else if (busy) begin
         if (cx == cy) busy <= 1'b0;
         else if (cx > cy) cx <= cx - cy;
         else cy <= cy - cx;
      end
   end

   assign core_done   = busy && (cx == cy);
   assign core_result = cx;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_gcd(logic [W-1:0] a, logic [W-1:0] b);
      logic [W-1:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   typedef struct {
      logic [1:0]   id;
      logic [W-1:0] g;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   seen[$];
   int   n_rsp = 0;

   always @(negedge clock) begin
      if (reset) sb.delete();
      else begin
         for (int i = 0; i < N; i++)
            if (req_ready[i] && req_valid[i])
               sb.push_back('{id: 2'(i),
                  g: ref_gcd(req_x[i*W +: W], req_y[i*W +: W])});
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            seen.push_back(int'(rsp_id));
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_gcd", 32'(rsp_gcd), 32'(e.g));
            end
         end
      end
   end

   int         cyc = 0;
   int         acc_cyc, load_cyc, rsp_cyc, n_load;
   logic [3:0] acc_gnt;
   logic [W-1:0] load_x, load_y;

   task automatic set_req(int i, logic [W-1:0] x, logic [W-1:0] y);
      req_x[i*W +: W] = x;
      req_y[i*W +: W] = y;
      req_valid[i]    = 1'b1;
   endtask

   // One clock: observe at negedge, requesters drop valid once granted.
   task automatic step();
      logic [N-1:0] g;
      @(negedge clock);
      g = req_ready & req_valid;
      if (g != 0) begin
         acc_cyc = cyc;
         acc_gnt = req_ready;
      end
      if (core_load) begin
         n_load++;
         load_cyc = cyc;
         load_x   = core_x;
         load_y   = core_y;
      end
      if (rsp_valid && rsp_ready) rsp_cyc = cyc;
      cyc++;
      @(posedge clock);
      #1;
      req_valid = req_valid & ~g;
   endtask

   task automatic wait_rsps(int n, int maxc);
      int target;
      target = n_rsp + n;
      for (int k = 0; k < maxc && n_rsp < target; k++) step();
      chk("rsp_timeout", 32'(n_rsp >= target), 1);
   endtask

   task automatic chk_idle_outs(string pfx);
      chk({pfx, "_req_ready"}, 32'(req_ready), 0);
      chk({pfx, "_core_load"}, 32'(core_load), 0);
      chk({pfx, "_core_x"}, 32'(core_x), 0);
      chk({pfx, "_core_y"}, 32'(core_y), 0);
      chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
      chk({pfx, "_rsp_id"}, 32'(rsp_id), 0);
      chk({pfx, "_rsp_gcd"}, 32'(rsp_gcd), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int r0;
      reset     = 1'b1;
      req_valid = 4'b0110;
      req_x     = '0;
      req_y     = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_idle_outs("rst");
      @(posedge clock);
      #1;
      req_valid = '0;
      reset     = 1'b0;

      // Single request through the core.
      n_load = 0;
      set_req(2, 48, 18);
      wait_rsps(1, 100);
      chk("t1_loads", 32'(n_load), 1);
      chk("t1_load_cyc", 32'(load_cyc), 32'(acc_cyc + 1));
      chk("t1_gnt", 32'(acc_gnt), 32'b0100);
      chk("t1_core_x", 32'(load_x), 48);
      chk("t1_core_y", 32'(load_y), 18);
      chk("t1_gcd", 32'(rsp_gcd), 6);

      // Round robin from a fresh pointer, two rounds.
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      seen.delete();
      set_req(0, 12, 8);
      set_req(1, 9, 6);
      set_req(2, 25, 15);
      set_req(3, 14, 21);
      wait_rsps(4, 300);
      set_req(0, 100, 75);
      set_req(1, 7, 5);
      set_req(2, 64, 48);
      set_req(3, 30, 45);
      wait_rsps(4, 600);
      chk("t2_count", 32'(seen.size()), 8);
      for (int k = 0; k < seen.size(); k++)
         chk("t2_order", 32'(seen[k]), 32'(k % 4));

      // Zero-operand bypass.
      n_load = 0;
      set_req(1, 0, 35);
      wait_rsps(1, 20);
      chk("t3_loads", 32'(n_load), 0);
      chk("t3_lat", 32'(rsp_cyc), 32'(acc_cyc + 1));
      set_req(1, 0, 0);
      wait_rsps(1, 20);
      chk("t3z_loads", 32'(n_load), 0);
      chk("t3z_lat", 32'(rsp_cyc), 32'(acc_cyc + 1));

      // Response stall with a competing request pending.
      rsp_ready = 1'b0;
      set_req(0, 40, 24);
      for (int k = 0; k < 100 && !rsp_valid; k++) step();
      chk("t4_valid_seen", 32'(rsp_valid), 1);
      set_req(2, 50, 20);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("t4_hold_valid", 32'(rsp_valid), 1);
         chk("t4_hold_id", 32'(rsp_id), 0);
         chk("t4_hold_gcd", 32'(rsp_gcd), 8);
         chk("t4_hold_ready", 32'(req_ready), 0);
         @(posedge clock);
         #1;
      end
      rsp_ready = 1'b1;
      r0 = n_rsp;
      step();
      chk("t4_handshake", 32'(n_rsp - r0), 1);
      @(negedge clock);
      chk("t4_bubble_gnt", 32'(req_ready), 32'b0100);
      @(posedge clock);
      #1;
      req_valid[2] = 1'b0;
      wait_rsps(1, 100);

      // Reset two cycles into RUN drops the request.
      set_req(1, 21, 14);
      for (int k = 0; k < 20 && !core_load; k++) step();
      chk("t5_load_seen", 32'(core_load), 1);
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk_idle_outs("t5");
      r0 = n_rsp;
      repeat (10) step();
      chk("t5_no_rsp", 32'(n_rsp - r0), 0);
      set_req(0, 18, 12);
      set_req(1, 35, 10);
      set_req(2, 81, 27);
      set_req(3, 16, 40);
      @(negedge clock);
      chk("t5_ptr0", 32'(req_ready), 32'b0001);
      @(posedge clock);
      #1;
      req_valid[0] = 1'b0;
      wait_rsps(4, 400);

      // Equal operands finish on the first compare; pointer wraps.
      n_load = 0;
      set_req(3, 9, 9);
      wait_rsps(1, 50);
      chk("t6_loads", 32'(n_load), 1);
      chk("t6_lat", 32'(rsp_cyc), 32'(acc_cyc + 3));
      chk("t6_gcd", 32'(rsp_gcd), 9);
      set_req(3, 10, 4);
      set_req(0, 15, 6);
      @(negedge clock);
      chk("t6_wrap", 32'(req_ready), 32'b0001);
      @(posedge clock);
      #1;
      req_valid[0] = 1'b0;
      wait_rsps(2, 200);
      chk("sb_drained", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
